helios_host_stream_driver: RTL

Host-side counterpart of the decoder's 8-bit byte-stream interface. It accepts one full syndrome block (all measurement rounds) as a parallel vector and serializes it into the decoder's input stream as a header byte followed by per-round packed measurement bytes. It then collects a fixed number of result bytes from the decoder's output stream into a parallel result word. Used as the front end in single-FPGA test harnesses and host bridges.

---
 rtl/helios_host_stream_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/helios_host_stream_driver.sv
// helios_host_stream_driver
// Host-side driver for the decoder's 8-bit byte stream. It captures one full
// syndrome block and sends it as a header byte followed by per-round packed
// measurement bytes. It then collects RESULT_BYTES bytes back into a parallel
// result word.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   syndrome / _valid / _ready        parallel syndrome block in
//                                     (round r at [r*ROUND_BITS +: ROUND_BITS])
//   tx_data / tx_valid / tx_ready     byte stream to the decoder input
//   rx_data / rx_valid / rx_ready     byte stream from the decoder output
//   result / result_valid / _ready    collected result word (byte k at [k*8 +: 8])
//   busy                              high whenever the driver is not idle
module helios_host_stream_driver #(
    parameter int          GRID_WIDTH_X = 4,
    parameter int          GRID_WIDTH_Z = 1,
    parameter int          GRID_WIDTH_U = 3,
    parameter int          RESULT_BYTES = 4,
    parameter logic [7:0]  HEADER_BYTE  = 8'h01
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*GRID_WIDTH_U-1:0] syndrome,
    input  logic                                           syndrome_valid,
    output logic                                           syndrome_ready,
    output logic [7:0]                                     tx_data,
    output logic                                           tx_valid,
    input  logic                                           tx_ready,
    input  logic [7:0]                                     rx_data,
    input  logic                                           rx_valid,
    output logic                                           rx_ready,
    output logic [RESULT_BYTES*8-1:0]                      result,
    output logic                                           result_valid,
    input  logic                                           result_ready,
    output logic                                           busy
);

    localparam int ROUND_BITS  = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int ROUND_BYTES = (ROUND_BITS + 7) / 8;
    localparam int SYN_BITS    = ROUND_BITS * GRID_WIDTH_U;
    localparam int RND_W       = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int BYTE_W      = (ROUND_BYTES > 1) ? $clog2(ROUND_BYTES) : 1;
    localparam int IDX_W       = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

    localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(GRID_WIDTH_U - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(ROUND_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(RESULT_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_DATA,
        RECV,
        HOLD
    } state_e;

    state_e                         state_q, state_d;
    logic [SYN_BITS-1:0]            shadow_q, shadow_d;
    logic [7:0]                     tx_data_q, tx_data_d;
    logic                           tx_valid_q, tx_valid_d;
    logic [RND_W-1:0]               round_q, round_d;
    logic [BYTE_W-1:0]              byte_q, byte_d;
    logic [IDX_W-1:0]               rx_idx_q, rx_idx_d;
    logic [RESULT_BYTES-1:0][7:0]   result_q, result_d;

    // Each round is zero-extended to a whole number of bytes so padding bits
    // beyond ROUND_BITS always go out as 0 and never leak the next round.
    logic [GRID_WIDTH_U-1:0][ROUND_BYTES-1:0][7:0] padded;

    for (genvar r = 0; r < GRID_WIDTH_U; r++) begin : g_round
        assign padded[r] = (ROUND_BYTES*8)'(shadow_q[r*ROUND_BITS +: ROUND_BITS]);
    end

    logic              last_byte;
    logic [BYTE_W-1:0] next_byte;
    logic [RND_W-1:0]  next_round;

    assign last_byte  = (byte_q == LAST_BYTE);
    assign next_byte  = last_byte ? '0 : byte_q + BYTE_W'(1);
    assign next_round = last_byte ? round_q + RND_W'(1) : round_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            round_q    <= '0;
            byte_q     <= '0;
            rx_idx_q   <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            round_q    <= round_d;
            byte_q     <= byte_d;
            rx_idx_q   <= rx_idx_d;
            result_q   <= result_d;
        end
    end

    // Next-state and next-datapath logic. tx_data is always preloaded with the
    // byte for the current counters, so an accepted byte is replaced by the
    // next one on the same edge and tx_valid never bubbles.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        round_d    = round_q;
        byte_d     = byte_q;
        rx_idx_d   = rx_idx_q;
        result_d   = result_q;

        unique case (state_q)
            IDLE: begin
                if (syndrome_valid) begin
                    shadow_d   = syndrome;
                    tx_data_d  = HEADER_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (tx_ready) begin
                    tx_data_d = padded[0][0];
                    round_d   = '0;
                    byte_d    = '0;
                    state_d   = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (tx_ready) begin
                    if (last_byte && round_q == LAST_ROUND) begin
                        tx_valid_d = 1'b0;
                        rx_idx_d   = '0;
                        state_d    = RECV;
                    end else begin
                        round_d   = next_round;
                        byte_d    = next_byte;
                        tx_data_d = padded[next_round][next_byte];
                    end
                end
            end
            RECV: begin
                if (rx_valid) begin
                    result_d[rx_idx_q] = rx_data;
                    if (rx_idx_q == LAST_IDX) begin
                        rx_idx_d = '0;
                        state_d  = HOLD;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        syndrome_ready = (state_q == IDLE);
        rx_ready       = (state_q == RECV);
        result_valid   = (state_q == HOLD);
        busy           = (state_q != IDLE);
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign result   = result_q;

endmodule
